// File: rtl/master_port_decoder.sv
// Per-master crossbar front end: decodes the target slave from the request address,
// drives this master's Req/NewTransaction bits and returns completion or error to the master.
module master_port_decoder #(
    parameter int NUM_OUTPUTS = 5,
    parameter int ADDR_WIDTH  = 32,
    parameter int SEL_MSB     = 31,
    parameter int SEL_LSB     = 28,
    parameter int TIMEOUT     = 255
) (
    input  logic                                 i_Clk,
    input  logic                                 i_Rst_n,
    input  logic                                 i_Mst_Valid,
    input  logic [ADDR_WIDTH-1:0]                i_Mst_Addr,
    output logic                                 o_Mst_Ready,
    output logic                                 o_Mst_Err,
    output logic [NUM_OUTPUTS-1:0]               o_Req,
    output logic [NUM_OUTPUTS-1:0]               o_NewTransaction,
    input  logic [NUM_OUTPUTS-1:0]               i_Grant,
    input  logic [NUM_OUTPUTS-1:0]               i_Slv_Ready,
    output logic [$clog2(NUM_OUTPUTS+1)-1:0]     o_RespSel
);

    localparam int SEL_W  = SEL_MSB - SEL_LSB + 1;
    localparam int RSEL_W = $clog2(NUM_OUTPUTS + 1);
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [RSEL_W-1:0] NO_TARGET = RSEL_W'(NUM_OUTPUTS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP,
        S_ERR
    } state_e;

    state_e                  state_q, state_d;
    logic [RSEL_W-1:0]       target_q, target_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic [SEL_W-1:0]        addr_idx;
    logic                    addr_mapped;
    logic [NUM_OUTPUTS-1:0]  target_oh;
    logic                    tgt_grant;
    logic                    tgt_done;
    logic                    tmo_hit;
    logic                    unused_addr;

    assign addr_idx    = i_Mst_Addr[SEL_MSB:SEL_LSB];
    assign addr_mapped = (32'(addr_idx) < 32'(NUM_OUTPUTS));
    // Only the select field matters; fold the rest so no address bit is left dangling.
    assign unused_addr = ^i_Mst_Addr;

    // Grant and ready on any slave other than the latched target are masked off here.
    assign target_oh = NUM_OUTPUTS'(1) << target_q;
    assign tgt_grant = |(i_Grant & target_oh);
    assign tgt_done  = tgt_grant & (|(i_Slv_Ready & target_oh));
    assign tmo_hit   = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q  <= S_IDLE;
            target_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        target_d         = target_q;
        cnt_d            = cnt_q;
        o_Req            = '0;
        o_NewTransaction = '0;
        o_Mst_Ready      = 1'b0;
        o_Mst_Err        = 1'b0;
        o_RespSel        = NO_TARGET;

        case (state_q)
            S_IDLE: begin
                if (i_Mst_Valid) begin
                    if (addr_mapped) begin
                        target_d = RSEL_W'(addr_idx);
                        cnt_d    = '0;
                        state_d  = S_REQ;
                    end else begin
                        state_d  = S_ERR;
                    end
                end
            end
            S_REQ: begin
                // NewTransaction stays up until a grant is seen so the arbiter can re-arbitrate.
                o_Req            = target_oh;
                o_NewTransaction = target_oh;
                o_RespSel        = target_q;
                cnt_d            = cnt_q + CNT_W'(1);
                if (tgt_done) begin
                    state_d = S_RESP;
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                end else if (tgt_grant) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                o_Req     = target_oh;
                o_RespSel = target_q;
                cnt_d     = cnt_q + CNT_W'(1);
                if (tgt_done) begin
                    state_d = S_RESP;
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                end
            end
            S_RESP: begin
                o_Mst_Ready = 1'b1;
                state_d     = S_IDLE;
            end
            S_ERR: begin
                o_Mst_Ready = 1'b1;
                o_Mst_Err   = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_master_port_decoder.sv
// Directed bench for master_port_decoder: expected responses queued at issue time and
// matched by a monitor; per-cycle Req/NewTransaction/RespSel checked inline.
module tb_master_port_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        va, vb;
    logic [31:0] addr;
    logic [4:0]  grant, sready;

    logic        a_ready, a_err, b_ready, b_err;
    logic [4:0]  a_req, a_nt, b_req, b_nt;
    logic [2:0]  a_sel, b_sel;

    always #5 clk = ~clk;

    master_port_decoder u_dut_a (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Mst_Valid(va), .i_Mst_Addr(addr),
        .o_Mst_Ready(a_ready), .o_Mst_Err(a_err), .o_Req(a_req),
        .o_NewTransaction(a_nt), .i_Grant(grant), .i_Slv_Ready(sready),
        .o_RespSel(a_sel)
    );

    master_port_decoder #(.TIMEOUT(4)) u_dut_b (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Mst_Valid(vb), .i_Mst_Addr(addr),
        .o_Mst_Ready(b_ready), .o_Mst_Err(b_err), .o_Req(b_req),
        .o_NewTransaction(b_nt), .i_Grant(grant), .i_Slv_Ready(sready),
        .o_RespSel(b_sel)
    );

    typedef struct {
        bit err;
        int cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input bit e, input int c);
        exp_t x;
        x.err = e;
        x.cyc = c;
        qa.push_back(x);
    endtask

    task automatic push_b(input bit e, input int c);
        exp_t x;
        x.err = e;
        x.cyc = c;
        qb.push_back(x);
    endtask

    task automatic chk_a(input string tag, input logic [4:0] req, input logic [4:0] nt,
                         input logic [2:0] sel);
        chk({tag, "_req"}, 32'(a_req), 32'(req));
        chk({tag, "_nt"},  32'(a_nt),  32'(nt));
        chk({tag, "_sel"}, 32'(a_sel), 32'(sel));
    endtask

    task automatic chk_b(input string tag, input logic [4:0] req, input logic [4:0] nt,
                         input logic [2:0] sel);
        chk({tag, "_req"}, 32'(b_req), 32'(req));
        chk({tag, "_nt"},  32'(b_nt),  32'(nt));
        chk({tag, "_sel"}, 32'(b_sel), 32'(sel));
    endtask

    // Monitor: every completion pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (a_ready) begin
            if (qa.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_a_unexpected: got ready (err=%0b) at cycle %0d, expected none", a_err, cyc);
            end else begin
                e = qa.pop_front();
                chk("sb_a_err", 32'(a_err), 32'(e.err));
                chk("sb_a_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        if (b_ready) begin
            if (qb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_b_unexpected: got ready (err=%0b) at cycle %0d, expected none", b_err, cyc);
            end else begin
                e = qb.pop_front();
                chk("sb_b_err", 32'(b_err), 32'(e.err));
                chk("sb_b_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic run_basic(input string tag);
        int c;
        c = cyc;
        addr = 32'h2000_0000;
        va = 1'b1;
        push_a(1'b0, c + 2);
        tick;
        va = 1'b0;
        chk_a({tag, "_c1"}, 5'b00100, 5'b00100, 3'd2);
        chk({tag, "_c1_rdy"}, 32'(a_ready), 32'd0);
        grant = 5'b00100;
        sready = 5'b00100;
        tick;
        grant = '0;
        sready = '0;
        chk_a({tag, "_c2"}, 5'b0, 5'b0, 3'd5);
        tick;
        chk_a({tag, "_c3"}, 5'b0, 5'b0, 3'd5);
        chk({tag, "_c3_rdy"}, 32'(a_ready), 32'd0);
        chk({tag, "_c3_err"}, 32'(a_err), 32'd0);
    endtask

    task automatic run_unmapped(input string tag, input logic [31:0] ad);
        int c;
        c = cyc;
        addr = ad;
        va = 1'b1;
        push_a(1'b1, c + 1);
        tick;
        va = 1'b0;
        chk_a({tag, "_c1"}, 5'b0, 5'b0, 3'd5);
        tick;
        chk_a({tag, "_c2"}, 5'b0, 5'b0, 3'd5);
    endtask

    // Timeout-configured instance: target 1, grant pattern selects timeout, late completion or WAIT timeout.
    task automatic run_tmo(input string tag, input int mode);
        int c;
        logic [4:0] nt_exp;
        c = cyc;
        addr = 32'h1000_0000;
        vb = 1'b1;
        push_b(mode != 1, c + 6);
        for (int k = 1; k <= 5; k++) begin
            tick;
            if (k == 1) vb = 1'b0;
            nt_exp = (mode == 2 && k > 3) ? 5'b0 : 5'b00010;
            chk_b($sformatf("%s_c%0d", tag, k), 5'b00010, nt_exp, 3'd1);
            grant  = '0;
            sready = '0;
            if (mode == 1 && k == 5) begin
                grant  = 5'b00010;
                sready = 5'b00010;
            end
            if (mode == 2 && k >= 3) grant = 5'b00010;
        end
        tick;
        grant = '0;
        sready = '0;
        chk_b({tag, "_c6"}, 5'b0, 5'b0, 3'd5);
        tick;
        chk_b({tag, "_c7"}, 5'b0, 5'b0, 3'd5);
    endtask

    initial begin
        int c;
        rst_n = 1'b0;
        va = 1'b0;
        vb = 1'b0;
        addr = '0;
        grant = '0;
        sready = '0;
        #12;
        chk_a("rst_a", 5'b0, 5'b0, 3'd5);
        chk("rst_a_rdy", 32'(a_ready), 32'd0);
        chk("rst_a_err", 32'(a_err), 32'd0);
        chk_b("rst_b", 5'b0, 5'b0, 3'd5);
        @(negedge clk);
        rst_n = 1'b1;
        tick;

        run_basic("basic");

        // Delayed grant on slave 1: three idle REQ cycles, two granted-not-ready, then ready.
        c = cyc;
        addr = 32'h1000_0000;
        va = 1'b1;
        push_a(1'b0, c + 7);
        for (int k = 1; k <= 6; k++) begin
            tick;
            if (k == 1) va = 1'b0;
            chk_a($sformatf("delay_c%0d", k), 5'b00010, (k <= 4) ? 5'b00010 : 5'b0, 3'd1);
            grant  = (k >= 4) ? 5'b00010 : 5'b0;
            sready = (k == 6) ? 5'b00010 : 5'b0;
        end
        tick;
        grant = '0;
        sready = '0;
        chk_a("delay_c7", 5'b0, 5'b0, 3'd5);
        tick;

        run_unmapped("unmap7", 32'h7000_0000);
        run_unmapped("unmap5", 32'h5000_0000);

        // Back-to-back to slave 0 with valid held: second request must re-enter REQ.
        c = cyc;
        addr = 32'h0000_0000;
        va = 1'b1;
        push_a(1'b0, c + 2);
        push_a(1'b0, c + 5);
        tick;
        chk_a("b2b_c1", 5'b00001, 5'b00001, 3'd0);
        grant = 5'b00001;
        sready = 5'b00001;
        tick;
        grant = '0;
        sready = '0;
        chk_a("b2b_c2", 5'b0, 5'b0, 3'd5);
        tick;
        chk_a("b2b_c3", 5'b0, 5'b0, 3'd5);
        tick;
        va = 1'b0;
        chk_a("b2b_c4", 5'b00001, 5'b00001, 3'd0);
        grant = 5'b00001;
        sready = 5'b00001;
        tick;
        grant = '0;
        sready = '0;
        tick;

        // Spurious non-target grant/ready while waiting on slave 3.
        c = cyc;
        addr = 32'h3000_0000;
        va = 1'b1;
        push_a(1'b0, c + 5);
        tick;
        va = 1'b0;
        chk_a("spur_c1", 5'b01000, 5'b01000, 3'd3);
        grant = 5'b01000;
        tick;
        chk_a("spur_c2", 5'b01000, 5'b0, 3'd3);
        grant = 5'b10111;
        sready = 5'b10111;
        tick;
        chk_a("spur_c3", 5'b01000, 5'b0, 3'd3);
        chk("spur_c3_rdy", 32'(a_ready), 32'd0);
        grant = 5'b01000;
        sready = 5'b10111;
        tick;
        chk_a("spur_c4", 5'b01000, 5'b0, 3'd3);
        chk("spur_c4_rdy", 32'(a_ready), 32'd0);
        sready = 5'b01000;
        tick;
        grant = '0;
        sready = '0;
        chk_a("spur_c5", 5'b0, 5'b0, 3'd5);
        tick;

        // Asynchronous reset in the middle of WAIT on slave 4.
        addr = 32'h4000_0000;
        va = 1'b1;
        tick;
        va = 1'b0;
        chk_a("arst_c1", 5'b10000, 5'b10000, 3'd4);
        grant = 5'b10000;
        tick;
        chk_a("arst_c2", 5'b10000, 5'b0, 3'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk_a("arst_now", 5'b0, 5'b0, 3'd5);
        chk("arst_now_rdy", 32'(a_ready), 32'd0);
        grant = '0;
        tick;
        tick;
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        run_basic("post_rst");

        run_tmo("tmo", 0);
        run_tmo("tmo_done", 1);
        run_tmo("tmo_wait", 2);

        tick;
        tick;
        chk("sb_a_drained", 32'(qa.size()), 32'd0);
        chk("sb_b_drained", 32'(qb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
